// File: rtl/vga_sdram_prefetcher_if.sv
// SDRAM read port of the VGA prefetcher: one outstanding word read, completed by a one-cycle ack.
interface vga_sdram_prefetcher_if #(
  parameter int ADDR_W = 22,
  parameter int WORD_W = 128
);
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [WORD_W-1:0] iread_data;
  logic              iread_ack;

  modport master (output oread_req, output oread_address, input iread_data, input iread_ack);
  modport slave  (input oread_req, input oread_address, output iread_data, output iread_ack);
endinterface

// File: rtl/vga_sdram_prefetcher.sv
// Streams a packed framebuffer from SDRAM through a small prefetch FIFO and unpacks it
// into registered RGB pixels for the VGA controller, with frame resync and sticky underflow.
module vga_sdram_prefetcher #(
  parameter int             H_ACTIVE      = 640,
  parameter int             V_ACTIVE      = 480,
  parameter int             BPP           = 12,
  parameter int             PIX_PER_WORD  = 10,
  parameter int             WORD_W        = 128,
  parameter int             FIFO_DEPTH    = 4,
  parameter int             ADDR_W        = 22,
  parameter logic [BPP-1:0] UNDERFLOW_RGB = '0
) (
  input  logic                             iclk_50,
  input  logic                             ireset_n,
  vga_sdram_prefetcher_if.master           sdram,
  input  logic [ADDR_W-1:0]                i_base_addr,
  input  logic                             i_frame_start,
  input  logic                             i_active_d,
  output logic [BPP/3-1:0]                 o_red,
  output logic [BPP/3-1:0]                 o_green,
  output logic [BPP/3-1:0]                 o_blue,
  output logic                             o_underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level
);

  localparam int WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int CNT_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int PIX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PACK_W = PIX_PER_WORD * BPP;
  localparam int CH_W   = BPP / 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_e;

  state_e             state_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   word_cnt_q;

  logic [PACK_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [PIX_W-1:0]   pix_idx_q;
  logic [BPP-1:0]     rgb_q;
  logic               underflow_q;

  logic               fifo_empty;
  logic               pix_last;
  logic               push;
  logic               pop;
  logic [PACK_W-1:0]  head_word;
  logic [BPP-1:0]     head_pixel;

  assign fifo_empty = (level_q == '0);
  assign pix_last   = (pix_idx_q == PIX_W'(PIX_PER_WORD - 1));
  // A frame start kills both the landing word and the pop of the current head.
  assign push       = (state_q == ST_REQ) && sdram.iread_ack && !i_frame_start;
  assign pop        = i_active_d && !i_frame_start && pix_last && !fifo_empty;
  assign head_word  = mem[rd_ptr_q];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    head_pixel = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (pix_idx_q == PIX_W'(k)) head_pixel = head_word[k*BPP +: BPP];
    end
  end

  // Fetch FSM: one outstanding read, request and address held until the ack.
  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge iclk_50 or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      base_q     <= '0;
      word_cnt_q <= '0;
    end else if (i_frame_start) begin
      base_q     <= i_base_addr;
      word_cnt_q <= '0;
      if (state_q != ST_IDLE) begin
        if (sdram.iread_ack) begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end else begin
          state_q <= ST_DISCARD;
        end
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (level_q < LVL_W'(FIFO_DEPTH)) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= base_q + ADDR_W'(word_cnt_q);
          end
        end
        ST_REQ: begin
          if (sdram.iread_ack) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            word_cnt_q <= (word_cnt_q == CNT_W'(WORDS_PER_FRAME - 1)) ? '0 : word_cnt_q + 1'b1;
          end
        end
        ST_DISCARD: begin
          if (sdram.iread_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; the level and pointers alone define what is valid.
  always_ff @(posedge iclk_50) begin
    if (push) mem[wr_ptr_q] <= sdram.iread_data[PACK_W-1:0];
  end

  always_ff @(posedge iclk_50 or negedge ireset_n) begin
    if (!ireset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_idx_q   <= '0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else if (i_frame_start) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pix_idx_q <= '0;
      rgb_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (i_active_d) begin
        // The raster index keeps moving on underflow so later words stay pixel-aligned.
        if (fifo_empty) begin
          rgb_q       <= UNDERFLOW_RGB;
          underflow_q <= 1'b1;
        end else begin
          rgb_q <= head_pixel;
        end
        pix_idx_q <= pix_last ? '0 : pix_idx_q + 1'b1;
      end else begin
        rgb_q <= '0;
      end
    end
  end

  generate
    if (PACK_W < WORD_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sdram.iread_data[WORD_W-1:PACK_W];
    end
  endgenerate

  assign sdram.oread_req     = req_q;
  assign sdram.oread_address = addr_q;
  assign o_red               = rgb_q[BPP-1 -: CH_W];
  assign o_green             = rgb_q[2*CH_W-1 -: CH_W];
  assign o_blue              = rgb_q[CH_W-1:0];
  assign o_underflow         = underflow_q;
  assign o_fifo_level        = level_q;

endmodule

// File: doc/vga_sdram_prefetcher.md
Name: vga_sdram_prefetcher

Overview:
- Parametrised successor to the VGA/SDRAM pixel adapter.
- Streams a packed framebuffer from SDRAM through a FIFO of FIFO_DEPTH prefetched words, so it can absorb SDRAM latency jitter.
- Unpacks PIX_PER_WORD pixels of BPP bits from each word into RGB for the VGA controller.
- Adds frame-start resynchronisation, a programmable base address, and sticky underflow detection.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BPP, 12, bits per pixel; must be a multiple of 3; order is {R,G,B} with B in the LSBs
- PIX_PER_WORD, 10, pixels packed per SDRAM word; pixel 0 occupies bits [BPP-1:0]
- WORD_W, 128, SDRAM word width; PIX_PER_WORD*BPP <= WORD_W
- FIFO_DEPTH, 4, prefetch words; power of two, >= 2
- ADDR_W, 22, SDRAM word address width
- UNDERFLOW_RGB, 0, BPP-bit colour emitted on underflow

Ports:
- iclk_50  in  1  system clock
- ireset_n  in  1  asynchronous active-low reset
- i_base_addr  in  ADDR_W  framebuffer start word address; sampled on i_frame_start
- i_frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- i_active_d  in  1  VGA controller requests one pixel this cycle
- oread_req  out  1  SDRAM read request
- oread_address  out  ADDR_W  word address for the current request
- iread_data  in  WORD_W  read data, valid while iread_ack=1
- iread_ack  in  1  read completion, one cycle
- o_red  out  BPP/3  pixel red
- o_green  out  BPP/3  pixel green
- o_blue  out  BPP/3  pixel blue
- o_underflow  out  1  sticky; a pixel was needed while the FIFO was empty
- o_fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently buffered

Behaviour:
- Reset (async assert, sync release):
  - oread_req=0, oread_address=0, RGB=0, o_underflow=0, FIFO empty, pixel index 0, read FSM in IDLE.
- Derived constant: WORDS_PER_FRAME = H_ACTIVE*V_ACTIVE/PIX_PER_WORD; must divide exactly.
- Fetch FSM, registered outputs, at most one request outstanding:
  - IDLE: if fifo_level + 0 < FIFO_DEPTH and not flushing -> REQ; assert oread_req next cycle, oread_address = base + word_cnt.
  - REQ: hold oread_req and oread_address stable until iread_ack.
    - On the ack cycle, write iread_data into the FIFO, increment word_cnt, go to IDLE.
    - oread_req drops the cycle after the ack.
    - Back-to-back requests are therefore separated by at least one idle cycle.
  - DISCARD: entered from REQ when i_frame_start arrives while a request is outstanding. Keep oread_req=1 until ack, drop the data, then go to IDLE.
- Address arithmetic:
  - word_cnt counts 0..WORDS_PER_FRAME-1 and wraps to 0.
  - oread_address = base_reg + word_cnt, modulo 2^ADDR_W.
- Pixel path:
  - Each cycle with i_active_d=1 consumes pixel pix_idx of the FIFO head word.
  - RGB is registered: valid exactly 1 cycle after the i_active_d sample.
  - When pix_idx == PIX_PER_WORD-1, pop the head and reset pix_idx to 0.
  - While i_active_d=0, RGB=0 and pix_idx is held.
- Underflow: if i_active_d=1 and the FIFO is empty:
  - output UNDERFLOW_RGB;
  - set o_underflow (cleared only by reset);
  - pix_idx still advances so the raster stays aligned; the word is treated as consumed when its last pixel passes.
- Simultaneous FIFO write (ack) and pop in the same cycle: the level is unchanged. A write arriving into an empty FIFO is not readable until the next cycle.
- i_frame_start, taking priority over everything except reset:
  - latches base_reg <= i_base_addr;
  - word_cnt=0, pix_idx=0, FIFO flushed (level 0);
  - a REQ in progress moves to DISCARD;
  - prefetch restarts the next cycle.
- i_frame_start coincident with iread_ack: the data is discarded and the FSM goes straight to IDLE.
- o_underflow is not cleared by i_frame_start.

Test Plan:
- Fill from reset:
  - Stimulus: release reset, pulse i_frame_start with base=0x100; the SDRAM model acks 3 cycles after each req.
  - Required: addresses 0x100..0x103 requested in order; o_fifo_level reaches 4; oread_req stays 0 once full.
- Pixel unpack:
  - Stimulus: word pixels p0..p9 = 0x001..0x00A; i_active_d high for 10 cycles.
  - Required: RGB sequence 0x001..0x00A, each one cycle after its request; head popped after p9; level drops to 3 and a refill request for 0x104 follows.
- Frame wrap:
  - Stimulus: H=20, V=2, PPW=10; stream continuously.
  - Required: addresses base+0..3, then base+0 again.
- Underflow:
  - Stimulus: SDRAM ack delayed 200 cycles, i_active_d continuously high.
  - Required: RGB=UNDERFLOW_RGB; o_underflow=1 and it stays 1 after data arrives and after i_frame_start.
- Frame start mid-request:
  - Stimulus: pulse i_frame_start while oread_req=1, with ack 2 cycles later.
  - Required: acked data not written (level stays 0); next request address = new base+0.
- Async reset mid-burst:
  - Stimulus: drop ireset_n with no clock edge.
  - Required: oread_req=0, RGB=0, level 0, o_underflow=0 immediately.
